// File: rtl/pdp_pkg.sv
// pdp_pkg: shared width, encoder constants, beat flag type and reference encoder
package pdp_pkg;
  localparam int DEF_W = 8;
  localparam int ADD_K = 1;
  localparam int MUL_K = 2;
  typedef struct packed {
    logic perr;
    logic ferr;
  } pdp_flags_t;
  function automatic logic [DEF_W-1:0] pdp_encode(input logic [DEF_W-1:0] x);
    return (x + DEF_W'(ADD_K)) * DEF_W'(MUL_K) - DEF_W'(1);
  endfunction
endpackage

// File: rtl/pdp_stage_reg.sv
// pdp_stage_reg: one pipeline stage holding data, valid and beat flags
module pdp_stage_reg
  import pdp_pkg::*;
#(
  parameter int DW = DEF_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  pdp_flags_t    in_flags,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output pdp_flags_t    out_flags
);
  logic          valid_d, valid_q;
  logic [DW-1:0] data_d, data_q;
  pdp_flags_t    flags_d, flags_q;
  // load a new beat when the pipeline advances, otherwise hold
  always_comb begin
    valid_d = en ? in_valid : valid_q;
    data_d  = en ? in_data : data_q;
    flags_d = en ? in_flags : flags_q;
  end
  // stage register; reset drops whatever beat is held
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      flags_q <= flags_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_flags = flags_q;
endmodule

// File: rtl/pipelined_data_decoder.sv
// pipelined_data_decoder: 3-stage stallable inverse of y = 2x+1 with parity/format error tracking
module pipelined_data_decoder
  import pdp_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_parity,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_perr,
  output logic             out_ferr,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  input  logic             clear
);
  localparam int W1 = W + 1;
  localparam logic [W-1:0] LOW_MASK = {1'b0, {(W-1){1'b1}}};
  logic             adv, err_hit;
  logic             s1_valid, s2_valid;
  logic [W-1:0]     s1_data, s3_in;
  logic [W:0]       s2_data, s2_in;
  pdp_flags_t       in_flags, s1_flags, s2_flags, s3_flags;
  logic [CNT_W-1:0] err_count_d, err_count_q;
  logic             err_sticky_d, err_sticky_q;
  // global stall, entry flags and the two decode arithmetic steps (sum kept W+1 wide so all-ones cannot wrap)
  always_comb begin
    adv           = !out_valid || out_ready;
    in_flags.perr = in_parity != ^in_data;
    in_flags.ferr = ~in_data[0];
    s2_in         = W1'(s1_data) + W1'(ADD_K);
    s3_in         = W'((s2_data >> 1) - W1'(1)) & LOW_MASK;
    err_hit       = out_valid && out_ready && (out_perr || out_ferr);
  end
  pdp_stage_reg #(.DW(W)) u_s1 (
    .clk(clk), .reset(reset), .en(adv), .in_valid(in_valid), .in_data(in_data), .in_flags(in_flags),
    .out_valid(s1_valid), .out_data(s1_data), .out_flags(s1_flags)
  );
  pdp_stage_reg #(.DW(W1)) u_s2 (
    .clk(clk), .reset(reset), .en(adv), .in_valid(s1_valid), .in_data(s2_in), .in_flags(s1_flags),
    .out_valid(s2_valid), .out_data(s2_data), .out_flags(s2_flags)
  );
  pdp_stage_reg #(.DW(W)) u_s3 (
    .clk(clk), .reset(reset), .en(adv), .in_valid(s2_valid), .in_data(s3_in), .in_flags(s2_flags),
    .out_valid(out_valid), .out_data(out_data), .out_flags(s3_flags)
  );
  // saturating error counter and sticky flag; clear beats a same-cycle errored transfer
  always_comb begin
    err_count_d  = clear ? '0 : (err_hit && err_count_q != '1) ? err_count_q + 1'b1 : err_count_q;
    err_sticky_d = clear ? 1'b0 : err_sticky_q | err_hit;
  end
  // error state register
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q  <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      err_count_q  <= err_count_d;
      err_sticky_q <= err_sticky_d;
    end
  end
  assign in_ready   = adv;
  assign out_perr   = s3_flags.perr;
  assign out_ferr   = s3_flags.ferr;
  assign err_count  = err_count_q;
  assign err_sticky = err_sticky_q;
endmodule

// File: tb/tb_pipelined_data_decoder.sv
// tb_pipelined_data_decoder: directed self-checking bench for pipelined_data_decoder
module tb_pipelined_data_decoder;
  import pdp_pkg::*;
  logic       clk = 1'b0;
  logic       reset, in_valid, in_parity, out_ready, clear;
  logic [7:0] in_data;
  logic       in_ready, out_valid, out_perr, out_ferr, err_sticky;
  logic [7:0] out_data, err_count;
  int         passed = 0, failed = 0, total = 0, cyc = 0, c0;
  logic [7:0] q_d[$], e_d[$];
  bit         q_p[$], q_f[$], e_p[$], e_f[$];
  int         q_c[$];

  pipelined_data_decoder #(.W(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_parity(in_parity), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_perr(out_perr), .out_ferr(out_ferr), .err_sticky(err_sticky), .err_count(err_count),
    .clear(clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (!reset && out_valid && out_ready) begin
      q_d.push_back(out_data);
      q_p.push_back(out_perr);
      q_f.push_back(out_ferr);
      q_c.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [7:0] y, input bit ok, input logic [7:0] ed, input bit ep, input bit ef);
    bit acc = 1'b0;
    in_valid  = 1'b1;
    in_data   = y;
    in_parity = (^y) ^ !ok;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    chk("accept", acc, 1);
    e_d.push_back(ed);
    e_p.push_back(ep);
    e_f.push_back(ef);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q_d.size() < e_d.size(); i++) tick();
  endtask

  task automatic compare(input string tag);
    chk({tag, " beats"}, q_d.size(), e_d.size());
    for (int i = 0; i < e_d.size() && i < q_d.size(); i++) begin
      chk({tag, " data"}, q_d[i], e_d[i]);
      chk({tag, " perr"}, q_p[i], e_p[i]);
      chk({tag, " ferr"}, q_f[i], e_f[i]);
    end
    q_d.delete(); q_p.delete(); q_f.delete(); q_c.delete();
    e_d.delete(); e_p.delete(); e_f.delete();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_parity = 1'b0; out_ready = 1'b1; clear = 1'b0;
    tick(); tick();
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_perr", out_perr, 0);
    chk("rst out_ferr", out_ferr, 0);
    chk("rst sticky", err_sticky, 0);
    chk("rst count", err_count, 0);
    reset = 1'b0;
    tick();
    // stream of three legal beats
    chk("t1 in_ready", in_ready, 1);
    c0 = cyc;
    send(8'h01, 1, 8'h00, 0, 0);
    send(8'h0B, 1, 8'h05, 0, 0);
    send(8'hFF, 1, 8'h7F, 0, 0);
    drain();
    chk("t1 lat0", q_c.size() > 0 ? q_c[0] : -1, c0 + 3);
    chk("t1 lat1", q_c.size() > 1 ? q_c[1] : -1, c0 + 4);
    chk("t1 lat2", q_c.size() > 2 ? q_c[2] : -1, c0 + 5);
    compare("t1");
    chk("t1 count", err_count, 0);
    // full encoder sweep
    for (int x = 0; x < 256; x++) send(pdp_encode(8'(x)), 1, 8'(x) & 8'h7F, 0, 0);
    drain();
    compare("t2");
    chk("t2 count", err_count, 0);
    chk("t2 sticky", err_sticky, 0);
    // parity error, then format error
    send(8'h0B, 0, 8'h05, 1, 0);
    drain();
    compare("t3a");
    chk("t3 sticky", err_sticky, 1);
    chk("t3 count1", err_count, 1);
    send(8'h10, 1, 8'h07, 0, 1);
    drain();
    compare("t3b");
    chk("t3 count2", err_count, 2);
    // stall with a 3-beat burst, the middle beat errored
    out_ready = 1'b0;
    send(8'h21, 1, 8'h10, 0, 0);
    send(8'h0B, 0, 8'h05, 1, 0);
    send(8'h35, 1, 8'h1A, 0, 0);
    in_valid = 1'b1; in_data = 8'h03; in_parity = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4 in_ready", in_ready, 0);
      chk("t4 out_valid", out_valid, 1);
      chk("t4 out_data", out_data, 8'h10);
      chk("t4 out_perr", out_perr, 0);
      tick();
    end
    in_valid = 1'b0;
    chk("t4 count held", err_count, 2);
    out_ready = 1'b1;
    drain();
    tick(); tick();
    compare("t4");
    chk("t4 count", err_count, 3);
    // saturation and clear priority
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5 cleared count", err_count, 0);
    chk("t5 cleared sticky", err_sticky, 0);
    for (int i = 0; i < 254; i++) send(8'h01, 0, 8'h00, 1, 0);
    drain();
    chk("t5 count fe", err_count, 8'hFE);
    for (int i = 0; i < 3; i++) send(8'h01, 0, 8'h00, 1, 0);
    drain();
    chk("t5 count sat", err_count, 8'hFF);
    chk("t5 sticky", err_sticky, 1);
    compare("t5a");
    send(8'h01, 0, 8'h00, 1, 0);
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    chk("t5 beat ready", out_valid, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5 clr count", err_count, 0);
    chk("t5 clr sticky", err_sticky, 0);
    compare("t5b");
    tick();
    chk("t5 clr hold", err_count, 0);
    // reset with two beats in flight
    send(8'h0B, 0, 8'h05, 1, 0);
    drain();
    compare("t6a");
    chk("t6 pre count", err_count, 1);
    in_valid = 1'b1; in_data = 8'h03; in_parity = 1'b0;
    tick();
    in_data = 8'h05; in_parity = 1'b0;
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6 out_valid", out_valid, 0);
    chk("t6 out_data", out_data, 0);
    chk("t6 count", err_count, 0);
    chk("t6 sticky", err_sticky, 0);
    for (int i = 0; i < 6; i++) tick();
    chk("t6 dropped", q_d.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
